// File: rtl/clock_divider_arbiter.sv
// Round-robin arbiter that lends a single programmable clock divider to one of
// NREQ requesters at a time; the owner's divisor sets the period of clksignal.
module clock_divider_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 24
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] divisor,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic                  clksignal,
  output logic [NREQ-1:0]       done,
  output logic [NREQ-1:0]       err
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t           state;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    owner;
  logic [WIDTH-1:0] dval;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] counter;

  logic             win_found;
  logic [IW-1:0]    win_idx;
  logic [IW:0]      sum;
  logic [IW-1:0]    cidx;
  logic [IW-1:0]    next_ptr;
  logic [WIDTH-1:0] divs [NREQ];

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      divs[i] = divisor[i*WIDTH +: WIDTH];
    end
  end

  // Scan requesters starting at the round-robin pointer, wrapping modulo NREQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    sum       = '0;
    cidx      = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr} + (IW+1)'(i);
      if (sum >= (IW+1)'(NREQ)) begin
        sum = sum - (IW+1)'(NREQ);
      end
      cidx = sum[IW-1:0];
      if (!win_found && req[cidx]) begin
        win_found = 1'b1;
        win_idx   = cidx;
      end
    end
  end

  assign next_ptr = (owner == IW'(NREQ-1)) ? '0 : owner + 1'b1;

  // The phase of clksignal doubles as the high/low phase flag while running.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      dval      <= '0;
      hi        <= '0;
      lo        <= '0;
      counter   <= '0;
      grant     <= '0;
      busy      <= 1'b0;
      clksignal <= 1'b0;
      done      <= '0;
      err       <= '0;
    end else begin
      done <= '0;
      err  <= '0;
      case (state)
        IDLE: begin
          busy      <= 1'b0;
          grant     <= '0;
          clksignal <= 1'b0;
          if (win_found) begin
            state <= LOAD;
            owner <= win_idx;
            grant <= onehot(win_idx);
            busy  <= 1'b1;
            dval  <= divs[win_idx];
          end
        end
        LOAD: begin
          if (dval < TWO) begin
            err   <= grant;
            grant <= '0;
            busy  <= 1'b0;
            ptr   <= next_ptr;
            state <= IDLE;
          end else begin
            hi        <= dval >> 1;
            lo        <= dval - (dval >> 1);
            counter   <= '0;
            clksignal <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (clksignal) begin
            if (counter == hi - ONE) begin
              clksignal <= 1'b0;
              counter   <= '0;
            end else begin
              counter <= counter + ONE;
            end
          end else if (counter == lo - ONE) begin
            // Release is only honoured here, at the end of a whole period.
            counter <= '0;
            if (req[owner]) begin
              clksignal <= 1'b1;
            end else begin
              state <= DONE;
              done  <= grant;
              grant <= '0;
              ptr   <= next_ptr;
            end
          end else begin
            counter <= counter + ONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_divider_arbiter.sv
// Scoreboard bench for clock_divider_arbiter: expected grants, phase lengths,
// done and err pulses are queued when stimulus is applied and matched by a monitor.
module tb_clock_divider_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 24;

  logic                  clock = 1'b0;
  logic                  rst = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] divisor = '0;
  logic [NREQ-1:0]       grant;
  logic                  busy;
  logic                  clksignal;
  logic [NREQ-1:0]       done;
  logic [NREQ-1:0]       err;

  int checks = 0;
  int errors = 0;
  int grantQ[$];
  int doneQ[$];
  int errQ[$];
  int hiQ[$];
  int loQ[$];

  logic            prevClk = 1'b0;
  logic [NREQ-1:0] prevGrant = '0;
  int              runLen = 0;
  bit              inPeriod = 1'b0;

  always #5 clock = ~clock;

  clock_divider_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clock(clock),
    .rst(rst),
    .req(req),
    .divisor(divisor),
    .grant(grant),
    .busy(busy),
    .clksignal(clksignal),
    .done(done),
    .err(err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] r);
    @(negedge clock);
    req = r;
  endtask

  task automatic setDiv(input int idx, input int val);
    divisor[idx*WIDTH +: WIDTH] = WIDTH'(val);
  endtask

  // One grant, n full periods of d cycles, then one done pulse for requester idx.
  task automatic expectService(input int idx, input int d, input int n);
    grantQ.push_back(1 << idx);
    for (int i = 0; i < n; i++) begin
      hiQ.push_back(d / 2);
      loQ.push_back(d - d / 2);
    end
    doneQ.push_back(1 << idx);
  endtask

  task automatic waitRises(input int n);
    int seen = 0;
    int budget = 0;
    logic prev;
    prev = clksignal;
    while (seen < n && budget < 5000) begin
      @(negedge clock);
      budget++;
      if (clksignal && !prev) seen++;
      prev = clksignal;
    end
    if (seen < n) checkOutput("rise_timeout", seen, n);
  endtask

  task automatic waitGrant(input bit nz);
    int budget = 0;
    while (((grant != '0) != nz) && budget < 200) begin
      @(negedge clock);
      budget++;
    end
    if ((grant != '0) != nz) checkOutput("grant_timeout", (grant != '0), nz);
  endtask

  // Wait for the next owner, let it run n periods, then drop its request mid-period.
  task automatic serveOwner(input int n);
    int owner = 0;
    waitGrant(1'b1);
    for (int i = 0; i < NREQ; i++) if (grant[i]) owner = i;
    waitRises(n);
    repeat (2) @(negedge clock);
    req[owner] = 1'b0;
    waitGrant(1'b0);
  endtask

  always @(negedge clock) begin
    if (!rst) begin
      prevClk   = 1'b0;
      prevGrant = '0;
      runLen    = 0;
      inPeriod  = 1'b0;
    end else begin
      if (grant != '0 && prevGrant == '0) begin
        if (grantQ.size() == 0) checkOutput("grant_extra", grant, 0);
        else checkOutput("grant_order", grant, grantQ.pop_front());
      end
      if (err != '0) begin
        if (errQ.size() == 0) checkOutput("err_extra", err, 0);
        else checkOutput("err_pulse", err, errQ.pop_front());
      end
      if (done != '0) begin
        if (doneQ.size() == 0) checkOutput("done_extra", done, 0);
        else checkOutput("done_pulse", done, doneQ.pop_front());
        if (loQ.size() == 0) checkOutput("final_low_extra", runLen, 0);
        else checkOutput("final_low_len", runLen, loQ.pop_front());
        inPeriod = 1'b0;
      end
      if (clksignal != prevClk) begin
        if (prevClk) begin
          if (hiQ.size() == 0) checkOutput("high_extra", runLen, 0);
          else checkOutput("high_len", runLen, hiQ.pop_front());
        end else if (inPeriod) begin
          if (loQ.size() == 0) checkOutput("low_extra", runLen, 0);
          else checkOutput("low_len", runLen, loQ.pop_front());
        end
        inPeriod = 1'b1;
        runLen   = 1;
      end else begin
        runLen++;
      end
      prevGrant = grant;
      prevClk   = clksignal;
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int hc;
    #3;
    checkOutput("reset_grant", grant, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_clk", clksignal, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_err", err, 0);
    @(posedge clock);
    #1 rst = 1'b1;
    setDiv(0, 10);
    setDiv(1, 7);
    setDiv(2, 1);
    setDiv(3, 4);

    // Single requester, divisor 10, five periods, first rise two cycles after sampling.
    expectService(0, 10, 5);
    applyStimulus(4'b0001);
    @(negedge clock);
    checkOutput("load_grant", grant, 4'b0001);
    checkOutput("load_busy", busy, 1);
    checkOutput("load_clk", clksignal, 0);
    @(negedge clock);
    checkOutput("first_rise", clksignal, 1);
    waitRises(4);
    repeat (2) @(negedge clock);
    req[0] = 1'b0;
    waitGrant(1'b0);
    checkOutput("done_busy", busy, 1);

    // Odd divisor with early release two cycles into the third period.
    expectService(1, 7, 3);
    applyStimulus(4'b0010);
    serveOwner(3);

    // Divisor 1 on requester 2: err pulse, no clock, grant moves on to 3.
    grantQ.push_back(4'b0100);
    errQ.push_back(4'b0100);
    expectService(3, 4, 2);
    applyStimulus(4'b1100);
    waitGrant(1'b1);
    checkOutput("bad_clk_load", clksignal, 0);
    req[2] = 1'b0;
    waitGrant(1'b0);
    checkOutput("bad_clk_idle", clksignal, 0);
    serveOwner(2);

    // Round robin over all requesters, then a sparse pattern from pointer 0.
    setDiv(0, 4);
    setDiv(1, 5);
    setDiv(2, 6);
    setDiv(3, 8);
    expectService(0, 4, 2);
    expectService(1, 5, 2);
    expectService(2, 6, 2);
    expectService(3, 8, 2);
    applyStimulus(4'b1111);
    repeat (4) serveOwner(2);
    expectService(0, 4, 2);
    expectService(2, 6, 2);
    applyStimulus(4'b0101);
    repeat (2) serveOwner(2);

    // Large divisor holds high without overflow, then reset mid high phase.
    setDiv(3, 10000000);
    grantQ.push_back(4'b1000);
    applyStimulus(4'b1000);
    waitGrant(1'b1);
    waitRises(1);
    hc = 0;
    repeat (20000) begin
      @(negedge clock);
      if (clksignal === 1'b1) hc++;
    end
    checkOutput("large_hold", hc, 20000);
    checkOutput("large_busy", busy, 1);
    checkOutput("large_grant", grant, 4'b1000);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_grant", grant, 0);
    checkOutput("async_clk", clksignal, 0);
    checkOutput("async_busy", busy, 0);
    req = '0;
    repeat (3) @(posedge clock);
    #1 rst = 1'b1;
    @(negedge clock);
    checkOutput("post_reset_grant", grant, 0);
    checkOutput("post_reset_busy", busy, 0);

    // After reset the pointer is back at 0, so requester 0 beats requester 3.
    setDiv(0, 4);
    setDiv(3, 4);
    expectService(0, 4, 1);
    expectService(3, 4, 1);
    applyStimulus(4'b1001);
    serveOwner(1);
    serveOwner(1);

    repeat (5) @(negedge clock);
    checkOutput("queues_empty", grantQ.size() + doneQ.size() + errQ.size() + hiQ.size() + loQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
